// File: rtl/cmp_serial.sv
// Sequential magnitude comparator: compares WIDTH-bit operands DIGIT bits per cycle, MSB slice first.
// Optional CMP_SERIAL_EARLY_EXIT_EN retires the result as soon as the decision is known.
module cmp_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             fi_big,
  input  logic             fi_equal,
  input  logic             fi_small,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fo_big,
  output logic             fo_equal,
  output logic             fo_small,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // flags are {big, equal, small}
  localparam logic [2:0] F_BIG   = 3'b100;
  localparam logic [2:0] F_EQUAL = 3'b010;
  localparam logic [2:0] F_SMALL = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic [2:0]       flags;
  logic [2:0]       fi_norm;
  logic [2:0]       slice_flags;
  logic [DIGIT-1:0] a_slice, b_slice;
  logic             accept;
  logic             step;

  always_comb begin
    if (fi_big)        fi_norm = F_BIG;
    else if (fi_small) fi_norm = F_SMALL;
    else if (fi_equal) fi_norm = F_EQUAL;
    else               fi_norm = F_EQUAL;  // no context asserted: treat as equal
  end

  assign a_slice = a_sh[WIDTH-1 -: DIGIT];
  assign b_slice = b_sh[WIDTH-1 -: DIGIT];

  always_comb begin
    if (a_slice > b_slice)      slice_flags = F_BIG;
    else if (a_slice < b_slice) slice_flags = F_SMALL;
    else                        slice_flags = F_EQUAL;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
`ifdef CMP_SERIAL_EARLY_EXIT_EN
          if (fi_norm != F_EQUAL) state_d = DONE;
`endif
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_d = DONE;
`ifdef CMP_SERIAL_EARLY_EXIT_EN
        if (flags == F_EQUAL && slice_flags != F_EQUAL) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      flags <= 3'b000;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      cnt   <= '0;
      flags <= fi_norm;
    end else if (step) begin
      // once a more significant slice has decided, later slices are ignored
      if (flags == F_EQUAL) flags <= slice_flags;
      a_sh <= a_sh << DIGIT;
      b_sh <= b_sh << DIGIT;
      cnt  <= cnt + CW'(1);
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign fo_big    = out_valid & flags[2];
  assign fo_equal  = out_valid & flags[1];
  assign fo_small  = out_valid & flags[0];

endmodule
